// File: rtl/program_memory.sv
// ============================================================================
// Module   : program_memory
// Purpose  : Synchronous instruction store with a write port, a registered
//            fetch and a hardware clear sequencer that fills the array with NOP.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_memory #(
    parameter int                 DATA_W   = 12,
    parameter int                 ADDR_W   = 4,
    parameter int                 DEPTH    = 16,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              rd_err
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // One extra bit so that DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_last  = (ADDR_W+1)'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    logic [ADDR_W:0]   r_clr_cnt;
    logic              r_ready;
    logic [DATA_W-1:0] r_instr;
    logic              r_instr_valid;
    logic              r_wr_err;
    logic              r_rd_err;

    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;

    assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
    assign w_rd_in_range = ({1'b0, pc} < c_depth);

    // Single array write port shared by the clear sequencer and the loader.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = '0;
        w_mem_data = NOP_WORD;
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_cnt[ADDR_W-1:0];
            end else if (wr_en && !clear_req && w_wr_in_range) begin
                w_mem_we   = 1'b1;
                w_mem_addr = wr_addr;
                w_mem_data = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_CLEAR;
            r_clr_cnt     <= '0;
            r_ready       <= 1'b0;
            r_instr       <= NOP_WORD;
            r_instr_valid <= 1'b0;
            r_wr_err      <= 1'b0;
            r_rd_err      <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_instr_valid <= 1'b0;
            r_rd_err      <= 1'b0;
            r_wr_err      <= wr_en;
            if (r_clr_cnt == c_last) begin
                r_state   <= ST_RUN;
                r_ready   <= 1'b1;
                r_clr_cnt <= '0;
            end else begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end else begin
            // Read samples the array before this edge's write lands.
            r_instr_valid <= rd_en;
            r_rd_err      <= rd_en && !w_rd_in_range;
            r_wr_err      <= wr_en && (clear_req || !w_wr_in_range);
            if (rd_en) begin
                r_instr <= w_rd_in_range ? r_mem[pc] : NOP_WORD;
            end
            if (clear_req) begin
                r_state   <= ST_CLEAR;
                r_ready   <= 1'b0;
                r_clr_cnt <= '0;
            end
        end
    end

    assign ready       = r_ready;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign wr_err      = r_wr_err;
    assign rd_err      = r_rd_err;

endmodule

`default_nettype wire

// File: doc/program_memory.md
Name: program_memory

Overview:
Parametrised, synchronous instruction store for the simple processor. Replaces the fixed 16x12 combinational ROM.
- Runtime write/load port.
- Registered fetch with a valid flag.
- Hardware clear sequencer that fills every word with NOP after reset or on request.
- Range checking on both ports.

Sits between the PC/fetch stage and the program loader/testbench.

Parameters:
- DATA_W, 12, instruction word width in bits.
- ADDR_W, 4, address width of pc and wr_addr.
- DEPTH, 16, implemented words; legal range 1..2**ADDR_W.
- NOP_WORD, 0 (DATA_W bits), fill value and out-of-range read value.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear_req  input  1  start a clear sequence (sampled only in RUN).
- ready  output  1  memory cleared and accepting reads/writes.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- wr_err  output  1  one-cycle pulse: write rejected.
- rd_en  input  1  fetch strobe.
- pc  input  ADDR_W  fetch address.
- instr  output  DATA_W  fetched instruction (registered).
- instr_valid  output  1  one-cycle pulse: instr updated by a fetch.
- rd_err  output  1  one-cycle pulse: fetch address out of range.

Behaviour:
- Reset is asynchronous, active-high. On assertion:
  - state=CLEAR, clr_cnt=0.
  - ready=0, instr=NOP_WORD, instr_valid=0, wr_err=0, rd_err=0.
  - Array contents are not touched by reset itself.
- Two-state FSM: CLEAR and RUN.
- CLEAR state:
  - Each edge writes NOP_WORD to mem[clr_cnt] and increments clr_cnt.
  - On the edge that writes DEPTH-1: go to RUN, ready<=1, clr_cnt<=0.
  - ready therefore rises exactly DEPTH edges after reset deassertion.
  - In CLEAR, rd_en is ignored (instr holds, instr_valid=0, rd_err=0).
  - In CLEAR, wr_en is dropped and wr_err pulses 1 the next cycle.
  - clear_req is ignored in CLEAR (no restart).
- RUN, clear_req=1:
  - Next edge: state=CLEAR, ready<=0.
  - A write in that same cycle is dropped with wr_err=1.
  - A read in that same cycle is serviced normally, returning pre-clear data.
- RUN write:
  - wr_en=1 and wr_addr<DEPTH: mem[wr_addr]<=wr_data at the edge.
  - wr_addr>=DEPTH: no write, wr_err<=1 for one cycle.
- RUN read, 1-cycle latency:
  - rd_en=1 and pc<DEPTH: instr<=mem[pc], instr_valid<=1.
  - pc>=DEPTH: instr<=NOP_WORD, instr_valid<=1, rd_err<=1.
  - rd_en=0: instr holds its last value, instr_valid<=0.
- Same-cycle read and write to the same address: read-before-write. instr gets the old word; the new word is visible from the next fetch.
- Pulse outputs (instr_valid, wr_err, rd_err) are registered and return to 0 the cycle after their cause unless re-triggered.
- Width rules:
  - clr_cnt is ADDR_W+1 bits, so DEPTH=2**ADDR_W terminates without wrap.
  - Address compares are unsigned.
  - No truncation of DATA_W anywhere.
- Reset mid-CLEAR or mid-RUN: immediate return to the reset values above; the clear restarts from address 0.

Test Plan:
1. Reset then idle, DEPTH=16: ready=0 for 16 edges, 1 on edge 16; a read of pc=0..15 then returns 12'h000 with instr_valid pulsing each cycle.
2. Write mem[0]=12'h120, mem[1]=12'h211, mem[2]=12'h320, then rd_en with pc=0,1,2 on consecutive cycles: instr=12'h120, 12'h211, 12'h320, each one cycle after its request; instr_valid high 3 cycles.
3. DEPTH=12 instance: write addr 13 -> wr_err pulse, no array change. Read pc=14 -> instr=NOP_WORD, instr_valid=1, rd_err=1.
4. Same cycle wr_en addr 5 data 12'hABC with rd_en pc=5 (old 12'h000): instr=12'h000. Next fetch of pc=5 gives 12'hABC.
5. In RUN, assert clear_req with a write to addr 2: ready drops next cycle, wr_err=1, reads are ignored for 16 cycles. After ready returns, pc=2 reads 12'h000.
6. Assert reset at clear count 7, release: ready stays 0 for a full 16 edges, and instr/valid/err outputs are at reset values.
